// File: rtl/mailbox_monitor.sv
// mailbox_monitor
// Passive snooper on the LSU AXI write channels. Writes to the simulation
// mailbox become a buffered console byte stream and sticky end-of-test status.
// AW and W are captured into small pairing queues because the two channels are
// independent. A pair is consumed either from the queue heads or directly from
// the incoming handshake when the matching queue is empty.
module mailbox_monitor #(
   parameter logic [31:0] MAILBOX_ADDR = 32'h80F8_0000,
   parameter int          FIFO_DEPTH   = 16,
   parameter int          MAX_CYCLES   = 99_000_000
) (
   input  logic        core_clk,
   input  logic        rst_l,
   input  logic        aw_valid,
   input  logic        aw_ready,
   input  logic [31:0] aw_addr,
   input  logic        w_valid,
   input  logic        w_ready,
   input  logic [63:0] w_data,
   input  logic [7:0]  w_strb,
   input  logic        w_last,
   output logic        char_valid,
   output logic [7:0]  char_data,
   input  logic        char_ready,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic        proto_err,
   output logic [15:0] drop_count,
   output logic [31:0] cycle_count
);

   localparam int               PTR_W      = $clog2(FIFO_DEPTH);
   localparam int               CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [31:0]      TIMEOUT_AT = 32'(MAX_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PASS    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   // ---------------- state flops ----------------
   state_e                        state_q, state_d;
   logic [3:0]                    aw_mem_q, aw_mem_d;
   logic [1:0]                    aw_rd_q, aw_rd_d, aw_wr_q, aw_wr_d;
   logic [2:0]                    aw_cnt_q, aw_cnt_d;
   logic [3:0][8:0]               w_mem_q, w_mem_d;
   logic [1:0]                    w_rd_q, w_rd_d, w_wr_q, w_wr_d;
   logic [2:0]                    w_cnt_q, w_cnt_d;
   logic                          w_first_q, w_first_d;
   logic [FIFO_DEPTH-1:0][7:0]    fifo_mem_q, fifo_mem_d;
   logic [PTR_W-1:0]              fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
   logic [CNT_W-1:0]              fifo_cnt_q, fifo_cnt_d;
   logic                          char_valid_q, char_valid_d;
   logic [7:0]                    char_data_q, char_data_d;
   logic                          pass_q, pass_d, fail_q, fail_d;
   logic                          timeout_q, timeout_d, done_q, done_d;
   logic                          proto_err_q, proto_err_d;
   logic [15:0]                   drop_count_q, drop_count_d;
   logic [31:0]                   cycle_count_q, cycle_count_d;

   // ---------------- combinational helpers ----------------
   logic        aw_ev_s, aw_hit_in_s, w_ev_s, w_push_s;
   logic        aw_have_s, w_have_s, pair_s, pair_hit_s;
   logic [8:0]  w_in_s, pair_w_s;
   logic        aw_pop_s, aw_store_s, aw_ok_s, aw_ovf_s;
   logic        w_pop_s, w_store_s, w_ok_s, w_ovf_s;
   logic        cls_en_s, is_pass_s, is_fail_s, push_char_s;
   logic        fifo_pop_s, fifo_push_ok_s, fifo_drop_s;
   logic [CNT_W-1:0] fifo_remain_s;
   logic        unused_ok;

   assign unused_ok   = ^{w_data[63:8], w_strb[7:1]};

   assign aw_ev_s     = aw_valid & aw_ready;
   assign aw_hit_in_s = (aw_addr == MAILBOX_ADDR);
   assign w_ev_s      = w_valid & w_ready;
   // only the first beat of each burst carries the mailbox byte
   assign w_push_s    = w_ev_s & w_first_q;
   assign w_in_s      = {w_strb[0], w_data[7:0]};

   assign aw_have_s   = (aw_cnt_q != 3'd0);
   assign w_have_s    = (w_cnt_q != 3'd0);
   assign pair_s      = (aw_have_s | aw_ev_s) & (w_have_s | w_push_s);
   assign pair_hit_s  = aw_have_s ? aw_mem_q[aw_rd_q] : aw_hit_in_s;
   assign pair_w_s    = w_have_s ? w_mem_q[w_rd_q] : w_in_s;

   // an incoming event is stored unless it is consumed directly by the pair
   assign aw_pop_s    = pair_s & aw_have_s;
   assign aw_store_s  = aw_ev_s & ~(pair_s & ~aw_have_s);
   assign aw_ok_s     = aw_store_s & ((aw_cnt_q != 3'd4) | aw_pop_s);
   assign aw_ovf_s    = aw_store_s & ~aw_ok_s;

   assign w_pop_s     = pair_s & w_have_s;
   assign w_store_s   = w_push_s & ~(pair_s & ~w_have_s);
   assign w_ok_s      = w_store_s & ((w_cnt_q != 3'd4) | w_pop_s);
   assign w_ovf_s     = w_store_s & ~w_ok_s;

   // classification stops once a terminal state is reached
   assign cls_en_s    = pair_s & pair_hit_s & pair_w_s[8] & (state_q == ST_RUN);
   assign is_pass_s   = cls_en_s & (pair_w_s[7:0] == 8'hFF);
   assign is_fail_s   = cls_en_s & (pair_w_s[7:0] == 8'h01);
   assign push_char_s = cls_en_s & (pair_w_s[7:0] >= 8'h06) & (pair_w_s[7:0] <= 8'h7E);

   // a pop on an empty FIFO does nothing, so a pushed byte shows next cycle
   assign fifo_pop_s     = (fifo_cnt_q != {CNT_W{1'b0}}) & char_ready;
   assign fifo_push_ok_s = push_char_s & ((fifo_cnt_q != FIFO_FULL) | fifo_pop_s);
   assign fifo_drop_s    = push_char_s & ~fifo_push_ok_s;
   assign fifo_remain_s  = fifo_cnt_q - CNT_W'(fifo_pop_s);

   // next-state computation for queues, console FIFO, FSM and counters
   always_comb begin
      // AW pairing queue
      aw_mem_d = aw_mem_q;
      if (aw_ok_s) begin
         aw_mem_d[aw_wr_q] = aw_hit_in_s;
      end else begin
         aw_mem_d = aw_mem_q;
      end
      aw_wr_d  = aw_wr_q + {1'b0, aw_ok_s};
      aw_rd_d  = aw_rd_q + {1'b0, aw_pop_s};
      aw_cnt_d = aw_cnt_q + {2'b00, aw_ok_s} - {2'b00, aw_pop_s};

      // W pairing queue
      w_mem_d = w_mem_q;
      if (w_ok_s) begin
         w_mem_d[w_wr_q] = w_in_s;
      end else begin
         w_mem_d = w_mem_q;
      end
      w_wr_d  = w_wr_q + {1'b0, w_ok_s};
      w_rd_d  = w_rd_q + {1'b0, w_pop_s};
      w_cnt_d = w_cnt_q + {2'b00, w_ok_s} - {2'b00, w_pop_s};

      if (w_ev_s) begin
         w_first_d = w_last;
      end else begin
         w_first_d = w_first_q;
      end

      proto_err_d = proto_err_q | aw_ovf_s | w_ovf_s;

      // console FIFO
      fifo_mem_d = fifo_mem_q;
      if (fifo_push_ok_s) begin
         fifo_mem_d[fifo_wr_q] = pair_w_s[7:0];
      end else begin
         fifo_mem_d = fifo_mem_q;
      end
      fifo_wr_d  = fifo_wr_q + PTR_W'(fifo_push_ok_s);
      fifo_rd_d  = fifo_rd_q + PTR_W'(fifo_pop_s);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_push_ok_s) - CNT_W'(fifo_pop_s);

      // head of the FIFO after this edge; a push into an emptied FIFO bypasses memory
      char_valid_d = (fifo_cnt_d != {CNT_W{1'b0}});
      if (!char_valid_d) begin
         char_data_d = 8'h00;
      end else if (fifo_remain_s == {CNT_W{1'b0}}) begin
         char_data_d = pair_w_s[7:0];
      end else begin
         char_data_d = fifo_mem_q[fifo_rd_d];
      end

      if (fifo_drop_s && (drop_count_q != 16'hFFFF)) begin
         drop_count_d = drop_count_q + 16'd1;
      end else begin
         drop_count_d = drop_count_q;
      end

      if (cycle_count_q != 32'hFFFF_FFFF) begin
         cycle_count_d = cycle_count_q + 32'd1;
      end else begin
         cycle_count_d = cycle_count_q;
      end

      // end-of-test FSM; a terminal code in the timeout cycle wins
      case (state_q)
         ST_RUN: begin
            if (is_pass_s) begin
               state_d = ST_PASS;
            end else if (is_fail_s) begin
               state_d = ST_FAIL;
            end else if (cycle_count_q == TIMEOUT_AT) begin
               state_d = ST_TIMEOUT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_PASS:    state_d = ST_PASS;
         ST_FAIL:    state_d = ST_FAIL;
         ST_TIMEOUT: state_d = ST_TIMEOUT;
         default:    state_d = ST_RUN;
      endcase

      pass_d    = (state_d == ST_PASS);
      fail_d    = (state_d == ST_FAIL);
      timeout_d = (state_d == ST_TIMEOUT);
      done_d    = (state_d != ST_RUN);
   end

   // all state, including the FSM and its registered status outputs
   always_ff @(posedge core_clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q       <= ST_RUN;
         aw_mem_q      <= 4'h0;
         aw_rd_q       <= 2'd0;
         aw_wr_q       <= 2'd0;
         aw_cnt_q      <= 3'd0;
         w_mem_q       <= '0;
         w_rd_q        <= 2'd0;
         w_wr_q        <= 2'd0;
         w_cnt_q       <= 3'd0;
         w_first_q     <= 1'b1;
         fifo_mem_q    <= '0;
         fifo_rd_q     <= '0;
         fifo_wr_q     <= '0;
         fifo_cnt_q    <= '0;
         char_valid_q  <= 1'b0;
         char_data_q   <= 8'h00;
         pass_q        <= 1'b0;
         fail_q        <= 1'b0;
         timeout_q     <= 1'b0;
         done_q        <= 1'b0;
         proto_err_q   <= 1'b0;
         drop_count_q  <= 16'h0000;
         cycle_count_q <= 32'h0000_0000;
      end else begin
         state_q       <= state_d;
         aw_mem_q      <= aw_mem_d;
         aw_rd_q       <= aw_rd_d;
         aw_wr_q       <= aw_wr_d;
         aw_cnt_q      <= aw_cnt_d;
         w_mem_q       <= w_mem_d;
         w_rd_q        <= w_rd_d;
         w_wr_q        <= w_wr_d;
         w_cnt_q       <= w_cnt_d;
         w_first_q     <= w_first_d;
         fifo_mem_q    <= fifo_mem_d;
         fifo_rd_q     <= fifo_rd_d;
         fifo_wr_q     <= fifo_wr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         char_valid_q  <= char_valid_d;
         char_data_q   <= char_data_d;
         pass_q        <= pass_d;
         fail_q        <= fail_d;
         timeout_q     <= timeout_d;
         done_q        <= done_d;
         proto_err_q   <= proto_err_d;
         drop_count_q  <= drop_count_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign char_valid  = char_valid_q;
   assign char_data   = char_data_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = timeout_q;
   assign done        = done_q;
   assign proto_err   = proto_err_q;
   assign drop_count  = drop_count_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mailbox_monitor.sv
// tb_mailbox_monitor: directed stimulus with a console-byte scoreboard.
// Expected bytes are queued when a write is issued; a negedge monitor pops
// and compares every byte the DUT hands over. Status outputs are checked
// directly after the relevant edges.
module tb_mailbox_monitor;

   localparam logic [31:0] MB = 32'h80F8_0000;

   logic        core_clk = 1'b0;
   logic        rst_l;
   logic        aw_valid, aw_ready;
   logic [31:0] aw_addr;
   logic        w_valid, w_ready;
   logic [63:0] w_data;
   logic [7:0]  w_strb;
   logic        w_last;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready;
   logic        done, pass, fail, timeout, proto_err;
   logic [15:0] drop_count;
   logic [31:0] cycle_count;

   int          tests  = 0;
   int          failed = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  mon_exp;

   always #5 core_clk = ~core_clk;

   mailbox_monitor #(
      .MAILBOX_ADDR(MB),
      .FIFO_DEPTH  (16),
      .MAX_CYCLES  (100)
   ) dut (
      .core_clk   (core_clk),
      .rst_l      (rst_l),
      .aw_valid   (aw_valid),
      .aw_ready   (aw_ready),
      .aw_addr    (aw_addr),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_data     (w_data),
      .w_strb     (w_strb),
      .w_last     (w_last),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .done       (done),
      .pass       (pass),
      .fail       (fail),
      .timeout    (timeout),
      .proto_err  (proto_err),
      .drop_count (drop_count),
      .cycle_count(cycle_count)
   );

   // scoreboard monitor: every accepted console byte must match the queue head
   always @(negedge core_clk) begin
      if (rst_l && char_valid && char_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL sb_unexpected: got %h, expected no byte", char_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (char_data !== mon_exp) begin
               failed++;
               $display("FAIL sb_char: got %h, expected %h", char_data, mon_exp);
            end
         end
      end
   end

   // hard stop in case the stimulus ever hangs
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge core_clk);
      #1;
   endtask

   task automatic idle();
      aw_valid = 1'b0;
      aw_ready = 1'b0;
      w_valid  = 1'b0;
      w_ready  = 1'b0;
      w_last   = 1'b0;
   endtask

   task automatic do_reset();
      rst_l = 1'b0;
      exp_q.delete();
      tick();
      tick();
      rst_l = 1'b1;
   endtask

   // single-beat write with AW and W in the same cycle
   task automatic mb_write(input logic [31:0] addr, input logic [7:0] data, input logic strb0);
      aw_valid = 1'b1;
      aw_ready = 1'b1;
      aw_addr  = addr;
      w_valid  = 1'b1;
      w_ready  = 1'b1;
      w_data   = {56'h0, data};
      w_strb   = {7'h00, strb0};
      w_last   = 1'b1;
      tick();
      idle();
   endtask

   initial begin
      idle();
      aw_addr    = 32'h0;
      w_data     = 64'h0;
      w_strb     = 8'h00;
      char_ready = 1'b0;
      do_reset();

      // reset values
      chk("rst_char_valid", {31'h0, char_valid}, 32'h0);
      chk("rst_char_data", {24'h0, char_data}, 32'h0);
      chk("rst_status", {27'h0, done, pass, fail, timeout, proto_err}, 32'h0);
      chk("rst_drop_count", {16'h0, drop_count}, 32'h0);
      chk("rst_cycle_count", cycle_count, 32'h0);

      // AW and W in the same cycle
      char_ready = 1'b1;
      exp_q.push_back(8'h41);
      mb_write(MB, 8'h41, 1'b1);
      chk("same_cycle_valid", {31'h0, char_valid}, 32'h1);
      chk("same_cycle_data", {24'h0, char_data}, 32'h41);
      chk("same_cycle_status", {30'h0, pass, fail}, 32'h0);

      // W three cycles ahead of AW
      w_valid = 1'b1; w_ready = 1'b1; w_data = 64'h48; w_strb = 8'h01; w_last = 1'b1;
      tick();
      idle();
      tick();
      tick();
      chk("w_only_no_char", {31'h0, char_valid}, 32'h0);
      aw_valid = 1'b1; aw_ready = 1'b1; aw_addr = MB;
      exp_q.push_back(8'h48);
      tick();
      idle();
      chk("w_first_valid", {31'h0, char_valid}, 32'h1);
      chk("w_first_data", {24'h0, char_data}, 32'h48);

      // non-mailbox address and disabled strobe produce nothing
      mb_write(MB + 32'd4, 8'h42, 1'b1);
      chk("miss_addr", {31'h0, char_valid}, 32'h0);
      mb_write(MB, 8'h43, 1'b0);
      chk("strb_off", {31'h0, char_valid}, 32'h0);

      // two-beat burst: only the first beat is a mailbox byte
      aw_valid = 1'b1; aw_ready = 1'b1; aw_addr = MB;
      w_valid = 1'b1; w_ready = 1'b1; w_data = 64'h44; w_strb = 8'h01; w_last = 1'b0;
      exp_q.push_back(8'h44);
      tick();
      aw_valid = 1'b0;
      w_data = 64'h45; w_last = 1'b1;
      tick();
      idle();
      tick();
      tick();
      chk("burst_tail_ignored", {31'h0, char_valid}, 32'h0);

      // FIFO overflow with the consumer stalled
      do_reset();
      char_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i < 16) exp_q.push_back(8'h61 + 8'(i));
         mb_write(MB, 8'h61 + 8'(i), 1'b1);
      end
      tick();
      chk("ovf_drop_count", {16'h0, drop_count}, 32'd4);
      chk("ovf_head_stable", {24'h0, char_data}, 32'h61);
      char_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      chk("ovf_drained", exp_q.size(), 32'd0);
      chk("ovf_empty_after", {31'h0, char_valid}, 32'h0);

      // PASS is terminal; later codes and bytes are ignored
      do_reset();
      mb_write(MB, 8'hFF, 1'b1);
      chk("pass_set", {28'h0, done, pass, fail, timeout}, 32'hC);
      mb_write(MB, 8'h01, 1'b1);
      mb_write(MB, 8'h41, 1'b1);
      tick();
      chk("pass_hold", {28'h0, done, pass, fail, timeout}, 32'hC);
      chk("pass_no_char", {31'h0, char_valid}, 32'h0);
      rst_l = 1'b0;
      #1;
      chk("async_rst_status", {27'h0, done, pass, fail, timeout, proto_err}, 32'h0);
      chk("async_rst_count", cycle_count, 32'h0);

      // timeout with no traffic
      do_reset();
      repeat (99) tick();
      chk("tmo_before_count", cycle_count, 32'd99);
      chk("tmo_before", {31'h0, timeout}, 32'h0);
      tick();
      chk("tmo_count", cycle_count, 32'd100);
      chk("tmo_set", {28'h0, done, pass, fail, timeout}, 32'h9);

      // pass code in the timeout cycle wins
      do_reset();
      repeat (99) tick();
      mb_write(MB, 8'hFF, 1'b1);
      chk("race_count", cycle_count, 32'd100);
      chk("race_pass", {28'h0, done, pass, fail, timeout}, 32'hC);
      tick();
      chk("race_hold", {28'h0, done, pass, fail, timeout}, 32'hC);

      // fail code
      do_reset();
      mb_write(MB, 8'h01, 1'b1);
      chk("fail_set", {28'h0, done, pass, fail, timeout}, 32'hA);

      // AW queue overflow
      do_reset();
      aw_valid = 1'b1; aw_ready = 1'b1; aw_addr = MB;
      repeat (4) tick();
      chk("aw_q_full_no_err", {31'h0, proto_err}, 32'h0);
      tick();
      idle();
      tick();
      chk("aw_q_ovf_err", {31'h0, proto_err}, 32'h1);

      // out-of-range bytes are not pushed; a printable one still is
      do_reset();
      mb_write(MB, 8'h00, 1'b1);
      mb_write(MB, 8'h05, 1'b1);
      mb_write(MB, 8'h7F, 1'b1);
      mb_write(MB, 8'h80, 1'b1);
      tick();
      chk("range_no_char", {31'h0, char_valid}, 32'h0);
      chk("range_no_status", {28'h0, done, pass, fail, timeout}, 32'h0);
      exp_q.push_back(8'h06);
      mb_write(MB, 8'h06, 1'b1);
      chk("range_low_edge", {24'h0, char_data}, 32'h06);
      exp_q.push_back(8'h7E);
      mb_write(MB, 8'h7E, 1'b1);
      chk("range_high_edge", {24'h0, char_data}, 32'h7E);
      tick();
      tick();
      chk("sb_final_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
